// File: rtl/lc3_mem_initiator_pkg.sv
// Shared types and widths for the LC3 memory initiator.
package lc3_mem_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;

   // Data-side operation requested by the core.
   typedef enum logic [1:0] {
      LD  = 2'd0,
      ST  = 2'd1,
      LDI = 2'd2,
      STI = 2'd3
   } mem_op_e;

   // Initiator sequencing states.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      IFETCH = 3'd1,
      DRD    = 3'd2,
      PTR    = 3'd3,
      WR     = 3'd4,
      RESP   = 3'd5
   } state_e;

   // States in which a completion from the responder is awaited (and the timeout runs).
   function automatic logic is_wait_state(state_e s);
      return (s == IFETCH) || (s == DRD) || (s == PTR);
   endfunction

endpackage

// File: rtl/lc3_mem_initiator_if.sv
// Bundle of the core-side handshake and the instruction/data memory bus.
interface lc3_mem_initiator_if;
   import lc3_mem_pkg::*;

   // core fetch channel
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_ack;
   logic [DATA_W-1:0] fetch_instr;

   // core data channel
   logic              mem_req;
   mem_op_e           mem_op;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic              err;

   // instruction memory
   logic [ADDR_W-1:0] pc;
   logic              instrmem_rd;
   logic [DATA_W-1:0] Instr_dout;
   logic              complete_instr;

   // data memory
   logic [ADDR_W-1:0] Data_addr;
   logic [DATA_W-1:0] Data_din;
   logic              Data_rd;
   logic [DATA_W-1:0] Data_dout;
   logic              complete_data;

   // The initiator itself.
   modport master (
      input  fetch_req, fetch_addr, mem_req, mem_op, mem_addr, mem_wdata,
      input  Instr_dout, complete_instr, Data_dout, complete_data,
      output fetch_ack, fetch_instr, mem_ack, mem_rdata, err,
      output pc, instrmem_rd, Data_addr, Data_din, Data_rd
   );

   // The core plus memory responder side.
   modport slave (
      output fetch_req, fetch_addr, mem_req, mem_op, mem_addr, mem_wdata,
      output Instr_dout, complete_instr, Data_dout, complete_data,
      input  fetch_ack, fetch_instr, mem_ack, mem_rdata, err,
      input  pc, instrmem_rd, Data_addr, Data_din, Data_rd
   );

endinterface

// File: rtl/lc3_mem_initiator_timeout_counter.sv
// Cycle counter bounding how long a waiting state may stall on the responder.
module lc3_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Clear takes priority so a state entry always starts counting from zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Last permitted cycle of the wait window.
   assign expired = enable && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/lc3_mem_initiator.sv
// LC3 memory initiator: arbitrates fetch vs data requests, sequences LDI/STI
// as pointer + data accesses, and bounds every wait with a timeout.
module lc3_mem_initiator
   import lc3_mem_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 16,
   parameter logic [15:0] RESET_PC       = 16'h3000
) (
   input  logic                clk,
   input  logic                reset,
   lc3_mem_initiator_if.master bus
);

   state_e            state_q;
   mem_op_e           op_q;
   logic              resp_fetch_q;
   logic              resp_err_q;
   logic [ADDR_W-1:0] pc_q;
   logic              instrmem_rd_q;
   logic              data_rd_q;
   logic [ADDR_W-1:0] data_addr_q;
   logic [DATA_W-1:0] data_din_q;
   logic              fetch_ack_q;
   logic              mem_ack_q;
   logic [DATA_W-1:0] fetch_instr_q;
   logic [DATA_W-1:0] mem_rdata_q;
   logic              err_q;

   logic tmo_en;
   logic tmo_clr;
   logic tmo_expired;

   // The counter runs only while waiting; a PTR completion moves straight into
   // DRD, so it must also clear there to give DRD a fresh window.
   assign tmo_en  = is_wait_state(state_q);
   assign tmo_clr = !tmo_en || ((state_q == PTR) && bus.complete_data);

   lc3_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (tmo_clr),
      .enable  (tmo_en),
      .expired (tmo_expired)
   );

   // Main sequencer; every bus output is a register written here.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         op_q          <= LD;
         resp_fetch_q  <= 1'b0;
         resp_err_q    <= 1'b0;
         pc_q          <= RESET_PC;
         instrmem_rd_q <= 1'b0;
         data_rd_q     <= 1'b1;
         data_addr_q   <= '0;
         data_din_q    <= '0;
         fetch_ack_q   <= 1'b0;
         mem_ack_q     <= 1'b0;
         fetch_instr_q <= '0;
         mem_rdata_q   <= '0;
         err_q         <= 1'b0;
      end else begin
         fetch_ack_q <= 1'b0;
         mem_ack_q   <= 1'b0;
         err_q       <= 1'b0;
         case (state_q)
            IDLE: begin
               // While an ack is visible the core has not yet dropped its
               // request, so accepting now would serve it twice.
               if (!(fetch_ack_q || mem_ack_q)) begin
                  if (bus.mem_req) begin
                     op_q         <= bus.mem_op;
                     data_addr_q  <= bus.mem_addr;
                     resp_fetch_q <= 1'b0;
                     resp_err_q   <= 1'b0;
                     case (bus.mem_op)
                        LD: begin
                           data_rd_q <= 1'b1;
                           state_q   <= DRD;
                        end
                        ST: begin
                           data_din_q <= bus.mem_wdata;
                           data_rd_q  <= 1'b0;
                           state_q    <= WR;
                        end
                        default: begin
                           data_rd_q <= 1'b1;
                           state_q   <= PTR;
                        end
                     endcase
                  end else if (bus.fetch_req) begin
                     pc_q          <= bus.fetch_addr;
                     instrmem_rd_q <= 1'b1;
                     resp_fetch_q  <= 1'b1;
                     resp_err_q    <= 1'b0;
                     state_q       <= IFETCH;
                  end
               end
            end
            IFETCH: begin
               if (bus.complete_instr) begin
                  fetch_instr_q <= bus.Instr_dout;
                  instrmem_rd_q <= 1'b0;
                  state_q       <= RESP;
               end else if (tmo_expired) begin
                  instrmem_rd_q <= 1'b0;
                  resp_err_q    <= 1'b1;
                  state_q       <= RESP;
               end
            end
            PTR: begin
               if (bus.complete_data) begin
                  data_addr_q <= bus.Data_dout;
                  if (op_q == STI) begin
                     data_din_q <= bus.mem_wdata;
                     data_rd_q  <= 1'b0;
                     state_q    <= WR;
                  end else begin
                     state_q <= DRD;
                  end
               end else if (tmo_expired) begin
                  // Abort the indirect op: the second access is never issued.
                  resp_err_q <= 1'b1;
                  state_q    <= RESP;
               end
            end
            DRD: begin
               if (bus.complete_data) begin
                  mem_rdata_q <= bus.Data_dout;
                  state_q     <= RESP;
               end else if (tmo_expired) begin
                  resp_err_q <= 1'b1;
                  state_q    <= RESP;
               end
            end
            WR: begin
               data_rd_q <= 1'b1;
               state_q   <= RESP;
            end
            RESP: begin
               if (resp_fetch_q) begin
                  fetch_ack_q <= 1'b1;
               end else begin
                  mem_ack_q <= 1'b1;
               end
               err_q   <= resp_err_q;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.pc          = pc_q;
   assign bus.instrmem_rd = instrmem_rd_q;
   assign bus.Data_rd     = data_rd_q;
   assign bus.Data_addr   = data_addr_q;
   assign bus.Data_din    = data_din_q;
   assign bus.fetch_ack   = fetch_ack_q;
   assign bus.fetch_instr = fetch_instr_q;
   assign bus.mem_ack     = mem_ack_q;
   assign bus.mem_rdata   = mem_rdata_q;
   assign bus.err         = err_q;

endmodule

// File: tb/tb_lc3_mem_initiator.sv
// Bench for lc3_mem_initiator: directed stimulus, expected acks queued into a
// scoreboard that a separate monitor pops whenever fetch_ack/mem_ack pulses.
module tb_lc3_mem_initiator;
   import lc3_mem_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   lc3_mem_initiator_if bus();

   lc3_mem_initiator #(
      .TIMEOUT_CYCLES (16),
      .RESET_PC       (16'h3000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- memory responder model ----------------
   logic [15:0] dmem [0:65535];
   logic        data_en;
   logic        instr_en;
   logic [15:0] instr_word;
   logic        pre_we;
   logic [15:0] pre_addr;
   logic [15:0] pre_data;

   assign bus.Data_dout     = dmem[bus.Data_addr];
   assign bus.complete_data = data_en;
   assign bus.Instr_dout    = instr_word;

   // Writes whenever Data_rd is low; instruction completion one cycle after the strobe.
   always @(posedge clk) begin
      if (pre_we) begin
         dmem[pre_addr] <= pre_data;
      end else if (reset && !bus.Data_rd) begin
         dmem[bus.Data_addr] <= bus.Data_din;
      end
      bus.complete_instr <= reset && bus.instrmem_rd && instr_en;
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      bit          is_fetch;
      logic [15:0] data;
      bit          chk_data;
      bit          err;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passed = 0;
   int   wr_cycles = 0;
   int   rd_cycles = 0;

   task automatic check(string name, logic [15:0] act, logic [15:0] exp);
      checks++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push(bit f, logic [15:0] d, bit cd, bit er, string nm);
      exp_t e;
      e.is_fetch = f;
      e.data     = d;
      e.chk_data = cd;
      e.err      = er;
      e.name     = nm;
      exp_q.push_back(e);
   endtask

   // Monitor: pops one expectation per ack pulse and tallies write/read strobe cycles.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (reset) begin
         if (bus.fetch_ack || bus.mem_ack) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_ack: fetch_ack=%0b mem_ack=%0b, expected no ack",
                        bus.fetch_ack, bus.mem_ack);
            end else begin
               e = exp_q.pop_front();
               $display("ack %s: fetch_ack=%0b mem_ack=%0b instr=%h rdata=%h err=%0b",
                        e.name, bus.fetch_ack, bus.mem_ack, bus.fetch_instr, bus.mem_rdata, bus.err);
               check({e.name, "_kind"}, 16'(bus.fetch_ack), 16'(e.is_fetch));
               if (e.chk_data) begin
                  if (e.is_fetch) check({e.name, "_data"}, bus.fetch_instr, e.data);
                  else            check({e.name, "_data"}, bus.mem_rdata, e.data);
               end
               check({e.name, "_err"}, 16'(bus.err), 16'(e.err));
            end
         end
         if (!bus.Data_rd)    wr_cycles++;
         if (bus.instrmem_rd) rd_cycles++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_ack(string name, bit fetch);
      int n = 0;
      while (!(fetch ? bus.fetch_ack : bus.mem_ack) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         checks++;
         $display("FAIL %s_wait: no ack within 40 cycles, expected an ack", name);
      end
   endtask

   task automatic preload(logic [15:0] a, logic [15:0] d);
      @(negedge clk);
      pre_we   = 1'b1;
      pre_addr = a;
      pre_data = d;
      @(negedge clk);
      pre_we   = 1'b0;
   endtask

   task automatic do_fetch(logic [15:0] a, logic [15:0] exp, bit cd, bit er, string nm);
      push(1'b1, exp, cd, er, nm);
      bus.fetch_addr = a;
      bus.fetch_req  = 1'b1;
      wait_ack(nm, 1'b1);
      bus.fetch_req  = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_mem(mem_op_e op, logic [15:0] a, logic [15:0] wd,
                         logic [15:0] exp, bit cd, bit er, string nm);
      push(1'b0, exp, cd, er, nm);
      bus.mem_op    = op;
      bus.mem_addr  = a;
      bus.mem_wdata = wd;
      bus.mem_req   = 1'b1;
      wait_ack(nm, 1'b0);
      bus.mem_req   = 1'b0;
      @(negedge clk);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int w0;
      int r0;
      bus.fetch_req  = 1'b0;
      bus.fetch_addr = '0;
      bus.mem_req    = 1'b0;
      bus.mem_op     = LD;
      bus.mem_addr   = '0;
      bus.mem_wdata  = '0;
      data_en        = 1'b1;
      instr_en       = 1'b1;
      instr_word     = '0;
      pre_we         = 1'b0;
      pre_addr       = '0;
      pre_data       = '0;

      // reset values
      repeat (3) @(negedge clk);
      check("rst_pc",          bus.pc, 16'h3000);
      check("rst_instrmem_rd", 16'(bus.instrmem_rd), 16'h0);
      check("rst_data_rd",     16'(bus.Data_rd), 16'h1);
      check("rst_data_addr",   bus.Data_addr, 16'h0);
      check("rst_data_din",    bus.Data_din, 16'h0);
      check("rst_fetch_ack",   16'(bus.fetch_ack), 16'h0);
      check("rst_mem_ack",     16'(bus.mem_ack), 16'h0);
      check("rst_fetch_instr", bus.fetch_instr, 16'h0);
      check("rst_mem_rdata",   bus.mem_rdata, 16'h0);
      check("rst_err",         16'(bus.err), 16'h0);
      reset = 1'b1;
      @(negedge clk);

      // plain fetch
      instr_word = 16'h1021;
      do_fetch(16'h3000, 16'h1021, 1'b1, 1'b0, "fetch1");
      repeat (3) @(negedge clk);
      check("fetch1_pc_hold", bus.pc, 16'h3000);
      check("fetch1_rd_drop", 16'(bus.instrmem_rd), 16'h0);

      // simultaneous ST and fetch: the store wins, then the fetch
      instr_word = 16'h5020;
      w0 = wr_cycles;
      push(1'b0, 16'h0, 1'b0, 1'b0, "st_first");
      push(1'b1, 16'h5020, 1'b1, 1'b0, "fetch_second");
      bus.mem_op     = ST;
      bus.mem_addr   = 16'h4000;
      bus.mem_wdata  = 16'hBEEF;
      bus.mem_req    = 1'b1;
      bus.fetch_addr = 16'h3002;
      bus.fetch_req  = 1'b1;
      wait_ack("st_first", 1'b0);
      bus.mem_req    = 1'b0;
      wait_ack("fetch_second", 1'b1);
      bus.fetch_req  = 1'b0;
      @(negedge clk);
      check("st_wr_cycles", 16'(wr_cycles - w0), 16'd1);
      check("st_mem4000",   dmem[16'h4000], 16'hBEEF);
      check("fetch2_pc",    bus.pc, 16'h3002);

      // LDI through a pointer
      preload(16'h4000, 16'h5000);
      preload(16'h5000, 16'h1234);
      do_mem(LDI, 16'h4000, 16'h0, 16'h1234, 1'b1, 1'b0, "ldi");

      // STI through a pointer
      preload(16'h4000, 16'h6000);
      w0 = wr_cycles;
      do_mem(STI, 16'h4000, 16'hA5A5, 16'h0, 1'b0, 1'b0, "sti");
      check("sti_mem6000",   dmem[16'h6000], 16'hA5A5);
      check("sti_mem4000",   dmem[16'h4000], 16'h6000);
      check("sti_wr_cycles", 16'(wr_cycles - w0), 16'd1);

      // plain LD
      preload(16'h4200, 16'h0F0F);
      do_mem(LD, 16'h4200, 16'h0, 16'h0F0F, 1'b1, 1'b0, "ld");

      // fetch timeout: strobe held for exactly 16 cycles then ack with err
      instr_en = 1'b0;
      r0 = rd_cycles;
      do_fetch(16'h3004, 16'h0, 1'b0, 1'b1, "fetch_tmo");
      check("fetch_tmo_rd_cycles", 16'(rd_cycles - r0), 16'd16);
      check("fetch_tmo_rd_drop",   16'(bus.instrmem_rd), 16'h0);
      instr_en = 1'b1;

      // STI timing out at the pointer read: aborted, no write issued
      data_en = 1'b0;
      w0 = wr_cycles;
      do_mem(STI, 16'h4000, 16'h7777, 16'h0, 1'b0, 1'b1, "sti_tmo");
      check("sti_tmo_no_write", 16'(wr_cycles - w0), 16'd0);
      do_mem(LD, 16'h4200, 16'h0, 16'h0, 1'b0, 1'b1, "ld_tmo");
      data_en = 1'b1;

      // reset asserted while waiting in DRD
      data_en      = 1'b0;
      bus.mem_op   = LD;
      bus.mem_addr = 16'h4100;
      bus.mem_req  = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrst_data_rd",   16'(bus.Data_rd), 16'h1);
      check("midrst_mem_ack",   16'(bus.mem_ack), 16'h0);
      check("midrst_data_addr", bus.Data_addr, 16'h0);
      check("midrst_pc",        bus.pc, 16'h3000);
      repeat (3) @(negedge clk);
      bus.mem_req = 1'b0;
      data_en     = 1'b1;
      reset       = 1'b1;
      repeat (2) @(negedge clk);
      check("postrst_pc",      bus.pc, 16'h3000);
      check("postrst_mem_ack", 16'(bus.mem_ack), 16'h0);
      instr_word = 16'h2468;
      do_fetch(16'h3006, 16'h2468, 1'b1, 1'b0, "fetch_after_rst");

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 16'(exp_q.size()), 16'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
